// File: rtl/dbg_cmd_engine.sv
// Debug packet engine: pops host command bytes, halts/resumes the CPU, accesses
// CPU memory, registers and PC breakpoints, and pushes replies to the tx FIFO.
module dbg_cmd_engine #(
    parameter int ADDR_BYTES = 2,
    parameter int NUM_BP     = 4,
    parameter int REG_SEL_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_empty,
    output logic                    rd_en,
    input  logic                    tx_full,
    output logic [7:0]              tx_data,
    output logic                    wr_en,
    input  logic                    parity_err,
    input  logic                    brk,
    input  logic [8*ADDR_BYTES-1:0] cpu_pc,
    input  logic                    cpu_pc_vld,
    input  logic                    cpumc_err,
    input  logic [7:0]              cpu_din,
    output logic [8*ADDR_BYTES-1:0] cpu_a,
    output logic [7:0]              cpu_dout,
    output logic                    cpu_r_nw,
    output logic                    cpu_ready,
    input  logic [7:0]              cpu_dbgreg_in,
    output logic [REG_SEL_W-1:0]    cpu_dbgreg_sel,
    output logic [7:0]              cpu_dbgreg_out,
    output logic                    cpu_dbgreg_wr,
    output logic                    bp_hit
);
    localparam int AW = 8 * ADDR_BYTES;

    localparam logic [7:0] OP_ECHO = 8'h00;
    localparam logic [7:0] OP_MRD  = 8'h01;
    localparam logic [7:0] OP_MWR  = 8'h02;
    localparam logic [7:0] OP_BRK  = 8'h03;
    localparam logic [7:0] OP_RUN  = 8'h04;
    localparam logic [7:0] OP_RRD  = 8'h05;
    localparam logic [7:0] OP_RWR  = 8'h06;
    localparam logic [7:0] OP_QRY  = 8'h07;
    localparam logic [7:0] OP_BPS  = 8'h08;
    localparam logic [7:0] OP_BPC  = 8'h09;
    localparam logic [7:0] OP_ERR  = 8'h0A;

    typedef enum logic [3:0] {
        S_DIS, S_DEC, S_ADDR, S_CNT, S_ECHO, S_MRD0, S_MRD1,
        S_MWR, S_REGRD, S_REGWS, S_REGWD, S_BPIDX
    } state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        addr_q, addr_d, addr_sh;
    logic [15:0]          cnt_q, cnt_d, cnt_sh;
    logic [7:0]           fld_q, fld_d;
    logic [7:0]           op_q, op_d;
    logic [7:0]           idx_q, idx_d;
    logic [REG_SEL_W-1:0] sel_q, sel_d;
    logic [3:0]           err_q, err_d, err_set;
    logic                 err_clr;
    logic [NUM_BP-1:0]    bp_en_q, bp_en_d;
    logic [AW-1:0]        bp_addr_q [NUM_BP];
    logic [AW-1:0]        bp_addr_d [NUM_BP];
    logic                 wr_en_q, push;
    logic [7:0]           tx_data_q, push_data;
    logic                 bp_match;

    assign tx_data        = tx_data_q;
    assign wr_en          = wr_en_q;
    assign cpu_a          = addr_q;
    assign cpu_dout       = rx_data;
    assign cpu_dbgreg_out = rx_data;
    assign cpu_ready      = (state_q == S_DIS);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        fld_d     = fld_q;
        op_d      = op_q;
        idx_d     = idx_q;
        sel_d     = sel_q;
        bp_en_d   = bp_en_q;
        bp_addr_d = bp_addr_q;
        err_set   = {1'b0, cpumc_err, 1'b0, parity_err};
        err_clr   = 1'b0;
        push      = 1'b0;
        push_data = tx_data_q;
        rd_en     = 1'b0;
        cpu_r_nw  = 1'b1;
        cpu_dbgreg_sel = sel_q;
        cpu_dbgreg_wr  = 1'b0;
        bp_hit    = 1'b0;
        // Fields arrive LSB first, so shift each new byte in from the top.
        addr_sh   = (addr_q >> 8) | (AW'(rx_data) << (AW - 8));
        cnt_sh    = {rx_data, cnt_q[15:8]};
        bp_match  = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_en_q[i] && bp_addr_q[i] == cpu_pc)
                bp_match = cpu_pc_vld;
        end

        unique case (state_q)
            S_DIS: begin
                if (brk || bp_match) begin
                    state_d = S_DEC;
                    bp_hit  = bp_match;
                end else if (!rx_empty) begin
                    rd_en = 1'b1;
                    case (rx_data)
                        OP_BRK: state_d = S_DEC;
                        OP_QRY: begin
                            push      = 1'b1;
                            push_data = 8'h00;
                        end
                        OP_ERR: begin
                            push      = 1'b1;
                            push_data = {4'h0, err_q};
                            err_clr   = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_DEC: begin
                if (!rx_empty) begin
                    rd_en = 1'b1;
                    fld_d = 8'd0;
                    op_d  = rx_data;
                    case (rx_data)
                        OP_ECHO:        state_d = S_CNT;
                        OP_MRD, OP_MWR: state_d = S_ADDR;
                        OP_BRK:         state_d = S_DEC;
                        OP_RUN:         state_d = S_DIS;
                        OP_RRD:         state_d = S_REGRD;
                        OP_RWR:         state_d = S_REGWS;
                        OP_BPS, OP_BPC: state_d = S_BPIDX;
                        OP_QRY: begin
                            push      = 1'b1;
                            push_data = 8'h01;
                        end
                        OP_ERR: begin
                            push      = 1'b1;
                            push_data = {4'h0, err_q};
                            err_clr   = 1'b1;
                        end
                        default: err_set[1] = 1'b1;
                    endcase
                end
            end
            S_ADDR: begin
                if (!rx_empty) begin
                    rd_en  = 1'b1;
                    addr_d = addr_sh;
                    fld_d  = fld_q + 8'd1;
                    if (fld_q == 8'(ADDR_BYTES - 1)) begin
                        fld_d   = 8'd0;
                        state_d = (op_q == OP_BPS) ? S_DEC : S_CNT;
                        if (op_q == OP_BPS && idx_q >= 8'(NUM_BP))
                            err_set[3] = 1'b1;
                        for (int i = 0; i < NUM_BP; i++) begin
                            if (op_q == OP_BPS && idx_q == 8'(i)) begin
                                bp_en_d[i]   = 1'b1;
                                bp_addr_d[i] = addr_sh;
                            end
                        end
                    end
                end
            end
            S_CNT: begin
                if (!rx_empty) begin
                    rd_en = 1'b1;
                    cnt_d = cnt_sh;
                    fld_d = fld_q + 8'd1;
                    if (fld_q == 8'd1) begin
                        fld_d = 8'd0;
                        if (cnt_sh == 16'd0)    state_d = S_DEC;
                        else if (op_q == OP_ECHO) state_d = S_ECHO;
                        else if (op_q == OP_MRD)  state_d = S_MRD0;
                        else                      state_d = S_MWR;
                    end
                end
            end
            S_ECHO: begin
                if (!rx_empty) begin
                    rd_en     = 1'b1;
                    push      = 1'b1;
                    push_data = rx_data;
                    cnt_d     = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) state_d = S_DEC;
                end
            end
            S_MRD0: state_d = S_MRD1;
            S_MRD1: begin
                if (!tx_full) begin
                    push      = 1'b1;
                    push_data = cpu_din;
                    addr_d    = addr_q + AW'(1);
                    cnt_d     = cnt_q - 16'd1;
                    state_d   = (cnt_q == 16'd1) ? S_DEC : S_MRD0;
                end
            end
            S_MWR: begin
                if (!rx_empty) begin
                    rd_en    = 1'b1;
                    cpu_r_nw = 1'b0;
                    addr_d   = addr_q + AW'(1);
                    cnt_d    = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) state_d = S_DEC;
                end
            end
            S_REGRD: begin
                cpu_dbgreg_sel = rx_data[REG_SEL_W-1:0];
                if (!rx_empty && !tx_full) begin
                    rd_en     = 1'b1;
                    push      = 1'b1;
                    push_data = cpu_dbgreg_in;
                    state_d   = S_DEC;
                end
            end
            S_REGWS: begin
                if (!rx_empty) begin
                    rd_en   = 1'b1;
                    sel_d   = rx_data[REG_SEL_W-1:0];
                    state_d = S_REGWD;
                end
            end
            S_REGWD: begin
                if (!rx_empty) begin
                    rd_en         = 1'b1;
                    cpu_dbgreg_wr = 1'b1;
                    state_d       = S_DEC;
                end
            end
            S_BPIDX: begin
                if (!rx_empty) begin
                    rd_en   = 1'b1;
                    idx_d   = rx_data;
                    state_d = (op_q == OP_BPS) ? S_ADDR : S_DEC;
                    if (op_q != OP_BPS && rx_data >= 8'(NUM_BP))
                        err_set[3] = 1'b1;
                    for (int i = 0; i < NUM_BP; i++) begin
                        if (op_q != OP_BPS && rx_data == 8'(i))
                            bp_en_d[i] = 1'b0;
                    end
                end
            end
            default: state_d = S_DIS;
        endcase

        // A new error event in the read cycle survives the clear.
        err_d = (err_clr ? 4'h0 : err_q) | err_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_DIS;
            addr_q    <= '0;
            cnt_q     <= '0;
            fld_q     <= '0;
            op_q      <= '0;
            idx_q     <= '0;
            sel_q     <= '0;
            err_q     <= '0;
            bp_en_q   <= '0;
            wr_en_q   <= 1'b0;
            tx_data_q <= '0;
            for (int i = 0; i < NUM_BP; i++) bp_addr_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            fld_q     <= fld_d;
            op_q      <= op_d;
            idx_q     <= idx_d;
            sel_q     <= sel_d;
            err_q     <= err_d;
            bp_en_q   <= bp_en_d;
            bp_addr_q <= bp_addr_d;
            wr_en_q   <= push;
            tx_data_q <= push_data;
        end
    end
endmodule

// File: tb/tb_dbg_cmd_engine.sv
// Directed bench for dbg_cmd_engine: modelled rx FIFO, CPU memory and registers,
// with a queue of expected tx bytes checked as the engine pushes them.
module tb_dbg_cmd_engine;
    logic        clk, rst;
    logic [7:0]  rx_data;
    logic        rx_empty, rd_en, tx_full, wr_en;
    logic [7:0]  tx_data;
    logic        parity_err, brk, cpu_pc_vld, cpumc_err;
    logic [15:0] cpu_pc, cpu_a;
    logic [7:0]  cpu_din, cpu_dout;
    logic        cpu_r_nw, cpu_ready;
    logic [7:0]  cpu_dbgreg_in, cpu_dbgreg_out;
    logic [3:0]  cpu_dbgreg_sel;
    logic        cpu_dbgreg_wr, bp_hit;

    logic [7:0]  mem [65536];
    logic [7:0]  regs [16];
    logic [7:0]  rxq [$];
    logic [7:0]  txq [$];
    logic [7:0]  mon_exp;
    int checks, passed, fails, tx_seen, bp_hits, tx_before;

    dbg_cmd_engine #(.ADDR_BYTES(2), .NUM_BP(4), .REG_SEL_W(4)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_empty(rx_empty),
        .rd_en(rd_en), .tx_full(tx_full), .tx_data(tx_data), .wr_en(wr_en),
        .parity_err(parity_err), .brk(brk), .cpu_pc(cpu_pc),
        .cpu_pc_vld(cpu_pc_vld), .cpumc_err(cpumc_err), .cpu_din(cpu_din),
        .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_r_nw(cpu_r_nw),
        .cpu_ready(cpu_ready), .cpu_dbgreg_in(cpu_dbgreg_in),
        .cpu_dbgreg_sel(cpu_dbgreg_sel), .cpu_dbgreg_out(cpu_dbgreg_out),
        .cpu_dbgreg_wr(cpu_dbgreg_wr), .bp_hit(bp_hit)
    );

    assign cpu_din       = mem[cpu_a];
    assign cpu_dbgreg_in = regs[cpu_dbgreg_sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            tx_seen++;
            if (txq.size() == 0) begin
                checks++;
                fails++;
                $error("FAIL tx_unexpected got=%h exp=none", tx_data);
            end else begin
                mon_exp = txq.pop_front();
                chk("tx_data", 32'(tx_data), 32'(mon_exp));
            end
        end
    end

    task automatic refresh();
        rx_empty = (rxq.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rxq[0];
    endtask

    task automatic send(input int n, input logic [63:0] v);
        for (int i = 0; i < n; i++) rxq.push_back(v[8*(n-1-i) +: 8]);
        refresh();
    endtask

    task automatic exp(input logic [7:0] b);
        txq.push_back(b);
    endtask

    // Inputs change only at posedge+1; outputs are observed on the negedge.
    task automatic step();
        logic pop;
        @(negedge clk);
        pop = rd_en;
        if (cpu_r_nw === 1'b0) mem[cpu_a] = cpu_dout;
        if (cpu_dbgreg_wr === 1'b1) regs[cpu_dbgreg_sel] = cpu_dbgreg_out;
        if (bp_hit === 1'b1) bp_hits++;
        @(posedge clk);
        #1;
        if (pop && rxq.size() > 0) void'(rxq.pop_front());
        refresh();
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((rxq.size() != 0 || txq.size() != 0) && k < 300) begin
            step();
            k++;
        end
        chk(tag, 32'(rxq.size() + txq.size()), 32'h0);
        repeat (2) step();
    endtask

    initial begin
        checks = 0; passed = 0; fails = 0; tx_seen = 0; bp_hits = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 16; i++) regs[i] = 8'h10 + 8'(i);
        rst = 1'b0; tx_full = 1'b0; parity_err = 1'b0; brk = 1'b0;
        cpu_pc = 16'h0; cpu_pc_vld = 1'b0; cpumc_err = 1'b0;
        refresh();
        #1 rst = 1'b1;
        #2;
        chk("rst_ready", 32'(cpu_ready), 32'h1);
        chk("rst_wr_en", 32'(wr_en), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_cpu_a", 32'(cpu_a), 32'h0);
        chk("rst_bp_hit", 32'(bp_hit), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        send(3, {8'h07, 8'h05, 8'h0A});
        exp(8'h00); exp(8'h00);
        drain("dis_cmds");
        chk("dis_ready", 32'(cpu_ready), 32'h1);

        send(2, {8'h03, 8'h07});
        exp(8'h01);
        drain("halt_query");
        chk("halted", 32'(cpu_ready), 32'h0);

        send(6, {8'h00, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC});
        exp(8'hAA); exp(8'hBB); exp(8'hCC);
        send(4, {8'h00, 8'h00, 8'h00, 8'h07});
        exp(8'h01);
        drain("echo");

        send(7, {8'h02, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h11, 8'h22});
        drain("mem_wr");
        chk("mem_ffff", 32'(mem[16'hFFFF]), 32'h11);
        chk("mem_0000", 32'(mem[16'h0000]), 32'h22);
        chk("mwr_addr_wrap", 32'(cpu_a), 32'h0001);

        send(5, {8'h01, 8'hFF, 8'hFF, 8'h02, 8'h00});
        exp(8'h11); exp(8'h22);
        drain("mem_rd");
        chk("mrd_addr_wrap", 32'(cpu_a), 32'h0001);

        send(3, {8'h06, 8'h03, 8'h5A});
        send(2, {8'h05, 8'h03});
        exp(8'h5A);
        drain("reg_rw");
        chk("reg3", 32'(regs[3]), 32'h5A);

        parity_err = 1'b1;
        step();
        parity_err = 1'b0;
        send(3, {8'h42, 8'h0A, 8'h0A});
        exp(8'h03); exp(8'h00);
        drain("err_par_unk");

        cpumc_err = 1'b1;
        step();
        cpumc_err = 1'b0;
        send(1, {8'h0A});
        exp(8'h04);
        drain("err_mc");

        send(6, {8'h08, 8'h04, 8'h00, 8'hD0, 8'h0A, 8'h0A});
        exp(8'h08); exp(8'h00);
        drain("bp_bad_idx");

        send(5, {8'h08, 8'h01, 8'h10, 8'hC0, 8'h04});
        drain("bp_set_run");
        chk("run_ready", 32'(cpu_ready), 32'h1);

        cpu_pc = 16'hD000; cpu_pc_vld = 1'b1;
        step();
        cpu_pc = 16'hC011;
        step();
        cpu_pc_vld = 1'b0;
        step();
        chk("bp_miss_ready", 32'(cpu_ready), 32'h1);
        chk("bp_miss_hits", 32'(bp_hits), 32'h0);

        cpu_pc = 16'hC010; cpu_pc_vld = 1'b1;
        step();
        cpu_pc_vld = 1'b0;
        step();
        chk("bp_hit_count", 32'(bp_hits), 32'h1);
        chk("bp_halt", 32'(cpu_ready), 32'h0);
        send(1, {8'h07});
        exp(8'h01);
        drain("bp_query");

        send(3, {8'h09, 8'h01, 8'h04});
        drain("bp_clr_run");
        cpu_pc_vld = 1'b1;
        step();
        cpu_pc_vld = 1'b0;
        step();
        chk("bp_clr_ready", 32'(cpu_ready), 32'h1);
        chk("bp_clr_hits", 32'(bp_hits), 32'h1);
        brk = 1'b1;
        step();
        brk = 1'b0;
        step();
        chk("brk_halt", 32'(cpu_ready), 32'h0);

        for (int i = 0; i < 4; i++) mem[16'h2000 + 16'(i)] = 8'hA1 + 8'(i);
        tx_full = 1'b1;
        tx_before = tx_seen;
        send(5, {8'h01, 8'h00, 8'h20, 8'h04, 8'h00});
        repeat (20) step();
        chk("stall_no_tx", 32'(tx_seen), 32'(tx_before));
        tx_full = 1'b0;
        for (int i = 0; i < 4; i++) exp(8'hA1 + 8'(i));
        drain("mrd_stall");
        chk("stall_addr", 32'(cpu_a), 32'h2004);

        send(5, {8'h01, 8'h00, 8'h30, 8'h02, 8'h00});
        for (int k = 0; k < 20 && rxq.size() != 0; k++) step();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(cpu_ready), 32'h1);
        chk("mid_rst_wr_en", 32'(wr_en), 32'h0);
        chk("mid_rst_tx", 32'(tx_data), 32'h0);
        chk("mid_rst_addr", 32'(cpu_a), 32'h0);
        step();
        rst = 1'b0;
        send(1, {8'h07});
        exp(8'h00);
        drain("post_rst");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
